// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types.
// Control word, data word, funct3 enums and memory-stage states.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic       load_regfile;
        logic [3:0] regfilemux_sel;
        rv32i_word  u_imm;
    } rv32i_control_word;

endpackage

// File: rtl/mem_store_align.sv
// Store lane alignment for the memory stage.
// Maps funct3 and byte offset to byte mask, shifted data and misalign flag.
module mem_store_align
    import rv32i_types::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  rv32i_word   i_rs2,
    output logic [3:0]  o_mbe,
    output rv32i_word   o_wdata,
    output logic        o_misalign
);

    logic w_byte;
    logic w_half;
    logic w_word;

    // Loads share the size encoding in funct3[1:0], so lhu/lbu align too.
    assign w_byte = (i_funct3[1:0] == 2'b00);
    assign w_half = (i_funct3[1:0] == 2'b01);
    assign w_word = (i_funct3[1:0] == 2'b10);

    assign o_wdata = i_rs2 << {i_offset, 3'b000};

    // Size-dependent lane mask and alignment check
    always_comb begin
        o_mbe      = 4'b0000;
        o_misalign = 1'b0;
        unique case (1'b1)
            w_byte: o_mbe = 4'b0001 << i_offset;
            w_half: begin
                o_mbe      = 4'b0011 << i_offset;
                o_misalign = i_offset[0];
            end
            w_word: begin
                o_mbe      = 4'b1111;
                o_misalign = |i_offset;
            end
            default: o_mbe = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rv32i memory-access stage and MEM/WB pipeline register.
// Issues one data-port transaction per memory op and stalls until done.
module mem_stage
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  rv32i_word         pc_in,
    input  rv32i_word         instruction_in,
    input  rv32i_control_word ctrl_word_in,
    input  rv32i_word         alu_in,
    input  rv32i_word         rs2_in,
    input  rv32i_word         br_en_in,
    input  logic              stall_in,
    output logic              data_read,
    output logic              data_write,
    output logic [3:0]        data_mbe,
    output rv32i_word         data_addr,
    output rv32i_word         data_wdata,
    input  rv32i_word         data_rdata,
    input  logic              data_resp,
    output logic              stall_out,
    output logic              misalign,
    output logic              mem_timeout,
    output logic              wb_valid,
    output rv32i_word         wb_pc,
    output rv32i_word         wb_instruction,
    output rv32i_control_word wb_ctrl,
    output rv32i_word         wb_alu,
    output rv32i_word         wb_br_en,
    output rv32i_word         wb_mdr,
    output logic [3:0]        wb_mem_byte_enable
);

    localparam logic [31:0] LP_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic [31:0]       r_count;
    rv32i_word         r_hold;
    logic              r_dropped;
    logic              r_misalign;
    logic              r_timeout;

    logic              r_wb_valid;
    rv32i_word         r_wb_pc;
    rv32i_word         r_wb_instr;
    rv32i_control_word r_wb_ctrl;
    rv32i_word         r_wb_alu;
    rv32i_word         r_wb_br_en;
    rv32i_word         r_wb_mdr;
    logic [3:0]        r_wb_be;

    logic              w_mem_op;
    logic              w_align_err;
    logic              w_expire;
    logic              w_req;
    logic              w_adv;
    logic              w_kill;
    logic              w_cap;
    logic              w_set_to;
    logic              w_set_drop;
    rv32i_word         w_mdr;
    logic [3:0]        w_mbe;
    rv32i_word         w_wdata;
    rv32i_control_word w_wb_ctrl;

    mem_store_align u_align (
        .i_funct3   (ctrl_word_in.funct3),
        .i_offset   (alu_in[1:0]),
        .i_rs2      (rs2_in),
        .o_mbe      (w_mbe),
        .o_wdata    (w_wdata),
        .o_misalign (w_align_err)
    );

    assign w_mem_op = in_valid
                    & (ctrl_word_in.mem_read | ctrl_word_in.mem_write);

    // A zero timeout leaves the watchdog permanently disarmed.
    assign w_expire = (TIMEOUT_CYCLES != 0) && (r_count == LP_LAST);

    assign data_read  = w_req & ctrl_word_in.mem_read;
    assign data_write = w_req & ctrl_word_in.mem_write;
    assign data_mbe   = data_write ? w_mbe : 4'b0000;
    assign data_addr  = {alu_in[31:2], 2'b00};
    assign data_wdata = w_wdata;

    assign misalign    = r_misalign;
    assign mem_timeout = r_timeout;

    assign wb_valid           = r_wb_valid;
    assign wb_pc              = r_wb_pc;
    assign wb_instruction     = r_wb_instr;
    assign wb_ctrl            = r_wb_ctrl;
    assign wb_alu             = r_wb_alu;
    assign wb_br_en           = r_wb_br_en;
    assign wb_mdr             = r_wb_mdr;
    assign wb_mem_byte_enable = r_wb_be;

    // Next-state, request, stall and MEM/WB advance decisions
    always_comb begin
        w_next     = r_state;
        w_req      = 1'b0;
        stall_out  = 1'b0;
        w_adv      = 1'b0;
        w_kill     = 1'b0;
        w_cap      = 1'b0;
        w_set_to   = 1'b0;
        w_set_drop = 1'b0;
        w_mdr      = '0;
        unique case (r_state)
            IDLE: begin
                if (w_mem_op && !w_align_err) begin
                    w_req     = 1'b1;
                    stall_out = 1'b1;
                    w_next    = ACCESS;
                end else begin
                    w_adv  = !stall_in;
                    w_kill = w_mem_op;
                end
            end
            ACCESS: begin
                w_req     = 1'b1;
                stall_out = 1'b1;
                if (data_resp) begin
                    stall_out = 1'b0;
                    w_cap     = 1'b1;
                    if (!stall_in) begin
                        w_adv  = 1'b1;
                        w_mdr  = data_rdata;
                        w_next = IDLE;
                    end else begin
                        w_next = DONE;
                    end
                end else if (w_expire) begin
                    stall_out = 1'b0;
                    w_set_to  = 1'b1;
                    if (!stall_in) begin
                        w_adv  = 1'b1;
                        w_kill = 1'b1;
                        w_next = IDLE;
                    end else begin
                        w_set_drop = 1'b1;
                        w_next     = DONE;
                    end
                end
            end
            DONE: begin
                stall_out = stall_in;
                if (!stall_in) begin
                    w_adv  = 1'b1;
                    w_kill = r_dropped;
                    w_mdr  = r_dropped ? '0 : r_hold;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Control word sent to writeback: bubbles clear it, dropped ops never write
    always_comb begin
        w_wb_ctrl              = ctrl_word_in;
        w_wb_ctrl.load_regfile = ctrl_word_in.load_regfile & ~w_kill;
        if (!in_valid) begin
            w_wb_ctrl = '0;
        end
    end

    // State, watchdog counter, response hold and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_hold     <= '0;
            r_dropped  <= 1'b0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ACCESS && w_next == ACCESS) begin
                r_count <= r_count + 32'd1;
            end else begin
                r_count <= '0;
            end
            if (w_cap) begin
                r_hold <= data_rdata;
            end
            if (r_state != DONE) begin
                r_dropped <= w_set_drop;
            end
            if (r_state == IDLE && w_mem_op && w_align_err) begin
                r_misalign <= 1'b1;
            end
            if (w_set_to) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // MEM/WB register: loads only when neither side is stalling
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb_pc    <= '0;
            r_wb_instr <= '0;
            r_wb_ctrl  <= '0;
            r_wb_alu   <= '0;
            r_wb_br_en <= '0;
            r_wb_mdr   <= '0;
            r_wb_be    <= '0;
        end else if (w_adv) begin
            r_wb_valid <= in_valid;
            r_wb_pc    <= pc_in;
            r_wb_instr <= instruction_in;
            r_wb_ctrl  <= w_wb_ctrl;
            r_wb_alu   <= alu_in;
            r_wb_br_en <= br_en_in;
            r_wb_mdr   <= w_mdr;
            r_wb_be    <= {2'b00, alu_in[1:0]};
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard testbench for mem_stage.
// Directed ops queue expected port requests and writeback slots.
module tb_mem_stage;
    import rv32i_types::*;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mbe;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic        lr;
        logic [31:0] alu;
        logic [31:0] br;
        logic [31:0] mdr;
        logic [3:0]  be;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    rv32i_word         pc_in = '0;
    rv32i_word         instruction_in = '0;
    rv32i_control_word ctrl_word_in = '0;
    rv32i_word         alu_in = '0;
    rv32i_word         rs2_in = '0;
    rv32i_word         br_en_in = '0;
    logic              stall_in = 1'b0;
    logic              data_read;
    logic              data_write;
    logic [3:0]        data_mbe;
    rv32i_word         data_addr;
    rv32i_word         data_wdata;
    rv32i_word         data_rdata = '0;
    logic              data_resp = 1'b0;
    logic              stall_out;
    logic              misalign;
    logic              mem_timeout;
    logic              wb_valid;
    rv32i_word         wb_pc;
    rv32i_word         wb_instruction;
    rv32i_control_word wb_ctrl;
    rv32i_word         wb_alu;
    rv32i_word         wb_br_en;
    rv32i_word         wb_mdr;
    logic [3:0]        wb_mem_byte_enable;

    mem_stage #(.TIMEOUT_CYCLES(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .pc_in              (pc_in),
        .instruction_in     (instruction_in),
        .ctrl_word_in       (ctrl_word_in),
        .alu_in             (alu_in),
        .rs2_in             (rs2_in),
        .br_en_in           (br_en_in),
        .stall_in           (stall_in),
        .data_read          (data_read),
        .data_write         (data_write),
        .data_mbe           (data_mbe),
        .data_addr          (data_addr),
        .data_wdata         (data_wdata),
        .data_rdata         (data_rdata),
        .data_resp          (data_resp),
        .stall_out          (stall_out),
        .misalign           (misalign),
        .mem_timeout        (mem_timeout),
        .wb_valid           (wb_valid),
        .wb_pc              (wb_pc),
        .wb_instruction     (wb_instruction),
        .wb_ctrl            (wb_ctrl),
        .wb_alu             (wb_alu),
        .wb_br_en           (wb_br_en),
        .wb_mdr             (wb_mdr),
        .wb_mem_byte_enable (wb_mem_byte_enable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rv32i_control_word mk(input logic r, input logic w,
                                             input logic [2:0] f3,
                                             input logic lr);
        rv32i_control_word c;
        c              = '0;
        c.mem_read     = r;
        c.mem_write    = w;
        c.funct3       = f3;
        c.rd           = 5'd5;
        c.load_regfile = lr;
        return c;
    endfunction

    task automatic issue(input logic [31:0] pc, input rv32i_control_word c,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] br);
        in_valid       = 1'b1;
        pc_in          = pc;
        instruction_in = pc ^ 32'h13;
        ctrl_word_in   = c;
        alu_in         = a;
        rs2_in         = d;
        br_en_in       = br;
    endtask

    // Monitor: port requests and new writeback slots against the queues
    logic        prev_req = 1'b0;
    logic        prev_resp = 1'b0;
    logic [31:0] last_pc = '0;
    req_t        cur;
    wb_t         ew;

    always @(negedge clk) begin
        logic req_now;
        req_now = data_read | data_write;
        if (req_now) begin
            if (!prev_req || prev_resp) begin
                if (req_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_req: got addr %h want none",
                             data_addr);
                end else begin
                    cur = req_q.pop_front();
                    chk("req_rd", 32'(data_read), 32'(cur.rd));
                    chk("req_wr", 32'(data_write), 32'(cur.wr));
                    chk("req_addr", data_addr, cur.addr);
                    chk("req_mbe", 32'(data_mbe), 32'(cur.mbe));
                    chk("req_wdata", data_wdata, cur.wdata);
                end
            end else begin
                chk("hold_addr", data_addr, cur.addr);
                chk("hold_mbe", 32'(data_mbe), 32'(cur.mbe));
                chk("hold_wdata", data_wdata, cur.wdata);
            end
        end
        prev_req  = req_now;
        prev_resp = data_resp;
        if (wb_valid && wb_pc != last_pc) begin
            last_pc = wb_pc;
            if (wb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_wb: got pc %h want none", wb_pc);
            end else begin
                ew = wb_q.pop_front();
                chk("wb_pc", wb_pc, ew.pc);
                chk("wb_lr", 32'(wb_ctrl.load_regfile), 32'(ew.lr));
                chk("wb_alu", wb_alu, ew.alu);
                chk("wb_br", wb_br_en, ew.br);
                chk("wb_mdr", wb_mdr, ew.mdr);
                chk("wb_be", 32'(wb_mem_byte_enable), 32'(ew.be));
            end
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_pc", wb_pc, 0);
        chk("rst_wb_ctrl", 32'(|wb_ctrl), 0);
        chk("rst_misalign", 32'(misalign), 0);
        chk("rst_timeout", 32'(mem_timeout), 0);
        chk("rst_stall", 32'(stall_out), 0);
        rst = 1'b1;
        tick();

        // sw 0x100
        issue(32'h1000, mk(0, 1, 3'b010, 0), 32'h100, 32'hDEADBEEF, 0);
        req_q.push_back('{1'b0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF});
        wb_q.push_back('{32'h1000, 1'b0, 32'h100, 0, 0, 4'h0});
        #1;
        chk("sw_stall_req", 32'(stall_out), 1);
        tick();
        data_resp = 1'b1;
        #1;
        chk("sw_stall_resp", 32'(stall_out), 0);
        tick();
        data_resp = 1'b0;

        // sb 0x103
        issue(32'h1004, mk(0, 1, 3'b000, 0), 32'h103, 32'hAB, 0);
        req_q.push_back('{1'b0, 1'b1, 32'h100, 4'b1000, 32'hAB000000});
        wb_q.push_back('{32'h1004, 1'b0, 32'h103, 0, 0, 4'h3});
        tick();
        data_resp = 1'b1;
        tick();
        data_resp = 1'b0;

        // lw 0x200, late response under downstream stall
        issue(32'h1008, mk(1, 0, 3'b010, 1), 32'h200, 0, 0);
        req_q.push_back('{1'b1, 1'b0, 32'h200, 4'h0, 32'h0});
        wb_q.push_back('{32'h1008, 1'b1, 32'h200, 0, 32'h12345678, 4'h0});
        repeat (3) tick();
        chk("lw_stall_wait", 32'(stall_out), 1);
        tick();
        data_resp  = 1'b1;
        data_rdata = 32'h12345678;
        stall_in   = 1'b1;
        #1;
        chk("lw_stall_resp", 32'(stall_out), 0);
        tick();
        data_resp  = 1'b0;
        data_rdata = 32'hFFFFFFFF;
        #1;
        chk("done_no_rereq", 32'(data_read), 0);
        chk("done_stall", 32'(stall_out), 1);
        chk("done_wb_hold", wb_pc, 32'h1004);
        repeat (3) tick();
        stall_in = 1'b0;
        #1;
        chk("done_release", 32'(stall_out), 0);
        tick();

        // sh 0x101 misaligned
        issue(32'h100C, mk(0, 1, 3'b001, 0), 32'h101, 32'h1234, 0);
        wb_q.push_back('{32'h100C, 1'b0, 32'h101, 0, 0, 4'h1});
        #1;
        chk("sh_no_write", 32'(data_write), 0);
        chk("sh_no_stall", 32'(stall_out), 0);
        tick();
        chk("sh_misalign", 32'(misalign), 1);

        // lw 0x202 misaligned, load_regfile must be dropped
        issue(32'h1010, mk(1, 0, 3'b010, 1), 32'h202, 0, 0);
        wb_q.push_back('{32'h1010, 1'b0, 32'h202, 0, 0, 4'h2});
        #1;
        chk("lwm_no_read", 32'(data_read), 0);
        tick();

        // non-memory op held one cycle by stall_in
        issue(32'h1014, mk(0, 0, 3'b000, 1), 32'h55, 0, 1);
        wb_q.push_back('{32'h1014, 1'b1, 32'h55, 1, 0, 4'h1});
        stall_in = 1'b1;
        #1;
        chk("alu_no_stall", 32'(stall_out), 0);
        tick();
        chk("alu_wb_hold", wb_pc, 32'h1010);
        stall_in = 1'b0;
        tick();

        // lw 0x300 watchdog expiry
        issue(32'h1018, mk(1, 0, 3'b010, 1), 32'h300, 0, 0);
        req_q.push_back('{1'b1, 1'b0, 32'h300, 4'h0, 32'h0});
        wb_q.push_back('{32'h1018, 1'b0, 32'h300, 0, 0, 4'h0});
        repeat (7) tick();
        chk("wd7_stall", 32'(stall_out), 1);
        chk("wd7_no_to", 32'(mem_timeout), 0);
        tick();
        chk("wd8_read", 32'(data_read), 1);
        chk("wd8_stall", 32'(stall_out), 0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("wd_timeout", 32'(mem_timeout), 1);
        chk("wd_dropped", 32'(data_read), 0);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst_clr_to", 32'(mem_timeout), 0);

        // lw 0x304 with response on the last watchdog cycle
        issue(32'h101C, mk(1, 0, 3'b010, 1), 32'h304, 0, 0);
        req_q.push_back('{1'b1, 1'b0, 32'h304, 4'h0, 32'h0});
        wb_q.push_back('{32'h101C, 1'b1, 32'h304, 0, 32'hCAFEF00D, 4'h0});
        repeat (8) tick();
        data_resp  = 1'b1;
        data_rdata = 32'hCAFEF00D;
        #1;
        chk("wdr_stall", 32'(stall_out), 0);
        tick();
        data_resp = 1'b0;
        chk("wdr_no_to", 32'(mem_timeout), 0);

        // lw 0x400 aborted by reset mid-access
        issue(32'h1020, mk(1, 0, 3'b010, 1), 32'h400, 0, 0);
        req_q.push_back('{1'b1, 1'b0, 32'h400, 4'h0, 32'h0});
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        chk("ra_read", 32'(data_read), 0);
        chk("ra_wb_valid", 32'(wb_valid), 0);
        chk("ra_wb_pc", wb_pc, 0);
        chk("ra_wb_ctrl", 32'(|wb_ctrl), 0);
        chk("ra_wb_alu", wb_alu, 0);
        chk("ra_wb_mdr", wb_mdr, 0);
        chk("ra_wb_be", 32'(wb_mem_byte_enable), 0);
        rst        = 1'b1;
        data_resp  = 1'b1;
        data_rdata = 32'h77;
        tick();
        data_resp = 1'b0;
        #1;
        chk("stale_wb_valid", 32'(wb_valid), 0);
        chk("stale_stall", 32'(stall_out), 0);
        chk("stale_read", 32'(data_read), 0);
        chk("stale_mdr", wb_mdr, 0);
        repeat (2) tick();

        chk("req_q_empty", 32'(req_q.size()), 0);
        chk("wb_q_empty", 32'(wb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the rv32i pipeline, between the EX/MEM register and the writeback stage.
- Converts the control word's load/store request into a data-port transaction: word address, byte mask, shifted store data.
- Holds the request until the port responds, stalling upstream meanwhile.
- Owns the MEM/WB pipeline register, which feeds writeback with PC, instruction, control word, ALU result, br_en, load word and byte offset.

Parameters:
TIMEOUT_CYCLES, 0, cycles to wait in ACCESS before abandoning a request; 0 disables the watchdog.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset; sampled only on the rising edge of clk
in_valid  in  1  EX/MEM slot holds a real instruction
pc_in  in  32  instruction PC
instruction_in  in  32  raw instruction
ctrl_word_in  in  rv32i_control_word  decoded control (mem_read, mem_write, funct3, rd, load_regfile, regfilemux_sel, u_imm)
alu_in  in  32  effective address / ALU result
rs2_in  in  32  store data
br_en_in  in  32  compare result, zero-extended
stall_in  in  1  downstream/global hold; MEM/WB register must not advance
data_read  out  1  data-port read request
data_write  out  1  data-port write request
data_mbe  out  4  write byte mask
data_addr  out  32  {alu_in[31:2],2'b00}
data_wdata  out  32  rs2_in shifted left by 8*alu_in[1:0]
data_rdata  in  32  read data
data_resp  in  1  single-cycle completion pulse
stall_out  out  1  upstream must hold EX/MEM stable
misalign  out  1  sticky: misaligned access dropped
mem_timeout  out  1  sticky: watchdog expired
wb_valid, wb_pc, wb_instruction, wb_ctrl, wb_alu, wb_br_en, wb_mdr  out  1/32/32/ctrl/32/32/32  MEM/WB register contents
wb_mem_byte_enable  out  4  {2'b00, alu_in[1:0]}; byte-lane select consumed by writeback

Behaviour:
- Reset (rst=0 at an edge):
  - State IDLE; all wb_* outputs 0, including wb_ctrl (so load_regfile=0).
  - misalign=0, mem_timeout=0, watchdog counter=0.
  - Reset mid-access aborts the access; no response is awaited afterwards.
- Memory op: in_valid & (mem_read|mem_write).
- Misaligned: half-word with alu_in[0]=1, or word with alu_in[1:0]!=0.
  - Misaligned op issues no request, sets misalign, and advances as a bubble-like slot with wb_ctrl.load_regfile forced 0.
- Store mask by funct3: sb 4'b0001<<off, sh 4'b0011<<off, sw 4'b1111. data_mbe is 0 for loads.
- States and transitions:
  - IDLE, aligned memory op: data_read/data_write asserted combinationally; stall_out=1; next state ACCESS. data_resp is ignored in IDLE.
  - ACCESS: request held asserted with identical addr/mbe/wdata; stall_out=1.
    - On data_resp, capture data_rdata into the internal hold register and deassert stall_out that cycle.
    - If also !stall_in: MEM/WB loads with wb_mdr=data_rdata; next state IDLE.
    - Else: next state DONE.
  - DONE: requests deasserted; the request is never reissued, which matters for stores. stall_out=1 while stall_in=1.
    - When stall_in=0: MEM/WB loads with wb_mdr from the hold register; stall_out=0; next state IDLE.
- Minimum memory-op latency: 2 cycles (request cycle, then resp in the next). stall_out is therefore high for at least 1 cycle.
- Non-memory slot in IDLE: stall_out=0; MEM/WB loads when !stall_in.
- Bubble (in_valid=0): wb_valid=0, wb_ctrl cleared.
- MEM/WB register holds all values whenever stall_in=1 or stall_out=1.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments in ACCESS and clears on leaving it.
  - When count reaches TIMEOUT_CYCLES without resp: drop the request, set mem_timeout, advance the slot with load_regfile=0, go to IDLE.
- data_resp arriving in the same cycle as the watchdog expiry: the response wins.
- Width: all data 32-bit; shifts use alu_in[1:0] only; upper address bits pass unchanged.

Decomposition:
- Shared package rv32i_types (existing): rv32i_control_word, rv32i_word, store_funct3/load_funct3 enums.
- New enum mem_state_t {IDLE, ACCESS, DONE} goes in the same package.
- One sub-module, mem_store_align: combinational funct3/offset -> data_mbe and data_wdata, plus the misalign flag. Unit-testable on its own.

Test Plan:
- sw addr 0x100, rs2=0xDEADBEEF, resp in 2nd cycle -> data_write=1, mbe=1111, wdata=0xDEADBEEF, stall_out high 1 cycle, wb_valid=1 next edge.
- sb addr 0x103, rs2=0x000000AB -> mbe=1000, wdata=0xAB000000, addr=0x100.
- lw addr 0x200, resp after 4 cycles with rdata=0x12345678 and stall_in=1 for 3 further cycles -> exactly one read request; state DONE; wb_mdr=0x12345678 once stall_in drops; no re-request.
- sh addr 0x101 -> no data_write, misalign=1, wb_ctrl.load_regfile=0, stall_out=0.
- TIMEOUT_CYCLES=8, no resp -> request drops after 8 ACCESS cycles, mem_timeout=1, slot advances; repeat with resp on the 8th cycle -> mem_timeout stays 0.
- rst=0 during ACCESS -> next edge: IDLE, data_read=0, all wb_* outputs 0; a stale data_resp the following cycle is ignored.
